mc_control_fsm: RTL

Multi-cycle control unit that sequences the single-issue RV32I datapath.
- Handshakes with instruction and data memory, which may have variable latency.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives every datapath control: regwe, dmemwe, rs2sel, regsel, ALUControl, plus PC/IR enables.
- Flags unsupported opcodes and counts retired instructions.

---
 rtl/mc_ctrl_pkg.sv | 47 ++++
 rtl/alu_decoder.sv | 41 ++++
 rtl/mc_control_fsm.sv | 97 +++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state, opcode, instruction-class and ALU encodings for the multi-cycle control unit
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_R,
        CL_I,
        CL_LOAD,
        CL_STORE,
        CL_BAD
    } iclass_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    function automatic iclass_t classify(input logic [6:0] op);
        return op == OP_R     ? CL_R     :
               op == OP_I     ? CL_I     :
               op == OP_LOAD  ? CL_LOAD  :
               op == OP_STORE ? CL_STORE : CL_BAD;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps {class, funct3, funct7_5} to ALUControl and a legal flag
// Ports: cls_i instruction class, funct3_i/funct7_5_i instruction fields,
//        alu_ctrl_o ALU operation, legal_o instruction is supported
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  iclass_t    cls_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output logic [3:0] alu_ctrl_o,
    output logic       legal_o
);

    alu_t base;
    logic is_alu;

    always_comb begin
        case (funct3_i)
            3'b000:  base = ALU_ADD;
            3'b001:  base = ALU_SLL;
            3'b010:  base = ALU_SLT;
            3'b011:  base = ALU_SLTU;
            3'b100:  base = ALU_XOR;
            3'b101:  base = funct7_5_i ? ALU_SRA : ALU_SRL;
            3'b110:  base = ALU_OR;
            default: base = ALU_AND;
        endcase
    end

    assign is_alu = cls_i == CL_R || cls_i == CL_I;

    // funct7_5 selects SUB only for register-register ops; ADDI ignores it
    assign alu_ctrl_o = (cls_i == CL_R && funct3_i == 3'b000 && funct7_5_i) ? ALU_SUB :
                        is_alu ? base : ALU_ADD;

    // only word loads/stores exist; SLLI with funct7_5 set has no meaning
    assign legal_o = cls_i == CL_R ? 1'b1 :
                     cls_i == CL_I ? !(funct3_i == 3'b001 && funct7_5_i) :
                     (cls_i == CL_LOAD || cls_i == CL_STORE) ? funct3_i == 3'b010 : 1'b0;

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle RV32I control unit sequencing FETCH/DECODE/EXEC/MEM/WB
// Ports: clk, reset (async active-low), run; opcode/funct3/funct7_5 from IR;
//        imem_ready/dmem_ready memory handshakes; imem_req, ir_we, pc_we, immsel,
//        rs2sel, ALUControl, dmem_req, dmemwe, regsel, regwe datapath controls;
//        illegal sticky flag, retired instruction count, state_dbg current state
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             immsel,
    output logic             rs2sel,
    output logic [3:0]       ALUControl,
    output logic             dmem_req,
    output logic             dmemwe,
    output logic             regsel,
    output logic             regwe,
    output logic             illegal,
    output logic [RET_W-1:0] retired,
    output logic [2:0]       state_dbg
);

    state_t           state_q;
    logic             illegal_q;
    logic [RET_W-1:0] retired_q;
    iclass_t          cls;
    logic [3:0]       alu_ctrl;
    logic             legal;
    logic             alu_phase;
    logic             is_mem;

    assign cls = classify(opcode);

    alu_decoder u_dec (
        .cls_i      (cls),
        .funct3_i   (funct3),
        .funct7_5_i (funct7_5),
        .alu_ctrl_o (alu_ctrl),
        .legal_o    (legal)
    );

    // ALU controls stay valid from EXEC through MEM/WB so the address and result hold steady
    assign alu_phase = state_q == S_EXEC || state_q == S_MEM || state_q == S_WB;
    assign is_mem    = cls == CL_LOAD || cls == CL_STORE;

    assign imem_req   = state_q == S_FETCH;
    assign ir_we      = imem_req && imem_ready;
    assign ALUControl = alu_phase ? alu_ctrl : 4'b0000;
    assign rs2sel     = alu_phase && cls != CL_R;
    assign immsel     = alu_phase && cls == CL_STORE;
    assign dmem_req   = state_q == S_MEM;
    assign dmemwe     = dmem_req && cls == CL_STORE;
    assign regwe      = state_q == S_WB;
    assign regsel     = regwe && cls != CL_LOAD;
    // stores retire in their final MEM cycle since they have no WB
    assign pc_we      = regwe || (dmemwe && dmem_ready);

    assign illegal   = illegal_q;
    assign retired   = retired_q;
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            retired_q <= retired_q + RET_W'(pc_we);
            case (state_q)
                S_IDLE:   state_q <= run ? S_FETCH : S_IDLE;
                S_FETCH:  state_q <= imem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    state_q   <= legal ? S_EXEC : S_HALT;
                    illegal_q <= !legal;
                end
                S_EXEC:   state_q <= is_mem ? S_MEM : S_WB;
                S_MEM:    state_q <= !dmem_ready ? S_MEM :
                                     cls == CL_LOAD ? S_WB :
                                     run ? S_FETCH : S_IDLE;
                S_WB:     state_q <= run ? S_FETCH : S_IDLE;
                default:  state_q <= S_HALT;
            endcase
        end
    end

endmodule
